uart_rx_byte: RTL

// - Asynchronous serial receiver, 8N1 (8E1 with parity option), LSB first, fixed baud.
// - Recovers bytes from the rx pin and presents them on rx_data with a 1-cycle rx_valid strobe.
// - Sits directly upstream of the two-digit seven-segment display driver, which consumes rx_data.
// - rx_data holds the last good byte between frames, so the display shows a stable value.
//

---
 rtl/uart_rx_byte.sv | 127 ++++++++++++
 1 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver holding the last good byte; defining UART_PARITY_EN
// switches the frame to 8E1 and adds parity checking.
module uart_rx_byte #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       rx_err_o
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int HALF     = BAUD_DIV / 2;
  localparam int CW       = $clog2(BAUD_DIV);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [2:0]    sync_q;
  logic          rx_s, fall, bit_end, perr;
`ifdef UART_PARITY_EN
  logic          par_q, par_d;
  assign perr = par_q;
`else
  assign perr = 1'b0;
`endif
  // sync_q[1] is the synchronized line, sync_q[2] its history for edge detection
  assign rx_s    = sync_q[1];
  assign fall    = sync_q[2] & ~sync_q[1];
  assign bit_end = cnt_q == CW'(BAUD_DIV - 1);
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q  <= 3'b111;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      sync_q  <= {sync_q[1:0], rx_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
`ifdef UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
`ifdef UART_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE:  state_d = fall ? START : IDLE;
      START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          state_d = rx_s ? IDLE : DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          sh_d  = {rx_s, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
`ifdef UART_PARITY_EN
          state_d = (bit_q == 3'd7) ? PARITY : DATA;
`else
          state_d = (bit_q == 3'd7) ? STOP : DATA;
`endif
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          par_d   = rx_s ^ (^sh_q);
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        // leaving at mid-stop-bit lets the next start edge be caught on time
        if (bit_end) begin
          valid_d = rx_s & ~perr;
          err_d   = ~rx_s | perr;
          data_d  = (rx_s & ~perr) ? sh_q : data_q;
          state_d = rx_s ? IDLE : BREAK;
        end
      end
      BREAK:   state_d = rx_s ? IDLE : BREAK;
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d != state_q || bit_end) ? '0 : cnt_q + 1'b1;
  end
  assign rx_data_o  = data_q;
  assign rx_valid_o = valid_q;
  assign rx_err_o   = err_q;
endmodule
